// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, default slave map and FSM state type for the Wishbone decoder
package wb_pkg;

    localparam int WB_DW         = 32;
    localparam int WB_AW         = 32;
    localparam int WB_SW         = WB_DW / 8;
    localparam int WB_NUM_SLAVES = 4;

    localparam logic [WB_AW-1:0] RAM_BASE   = 32'h0000_0000;
    localparam logic [WB_AW-1:0] RAM_MASK   = 32'hFFFF_8000;
    localparam logic [WB_AW-1:0] TIMER_BASE = 32'h8000_0000;
    localparam logic [WB_AW-1:0] TIMER_MASK = 32'hFFFF_F000;
    localparam logic [WB_AW-1:0] UART_BASE  = 32'h8000_1000;
    localparam logic [WB_AW-1:0] UART_MASK  = 32'hFFFF_F000;
    localparam logic [WB_AW-1:0] SPARE_BASE = 32'h8000_2000;
    localparam logic [WB_AW-1:0] SPARE_MASK = 32'hFFFF_F000;

    // Slot 0 occupies the least significant bits
    localparam logic [WB_NUM_SLAVES*WB_AW-1:0] WB_DEF_BASE =
        {SPARE_BASE, UART_BASE, TIMER_BASE, RAM_BASE};
    localparam logic [WB_NUM_SLAVES*WB_AW-1:0] WB_DEF_MASK =
        {SPARE_MASK, UART_MASK, TIMER_MASK, RAM_MASK};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - combinational base/mask priority decoder, lowest slot index wins
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter int                         NUM_SLAVES = WB_NUM_SLAVES,
    parameter int                         AW         = WB_AW,
    parameter int                         IW         = 2,
    parameter logic [NUM_SLAVES*AW-1:0]   SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*AW-1:0]   SLAVE_MASK = '0
) (
    input  logic [AW-1:0] i_adr,
    output logic          o_hit,
    output logic [IW-1:0] o_idx
);

    // Scan from the top so the lowest matching slot is the last assignment
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((i_adr & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
                o_hit = 1'b1;
                o_idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/wb_decoder_n.sv
// rtl/wb_decoder_n.sv - 1-master / N-slave Wishbone classic interconnect with decode-miss and time-out errors
module wb_decoder_n
    import wb_pkg::*;
#(
    parameter int                                   WB_DATA_WIDTH  = WB_DW,
    parameter int                                   WB_ADDR_WIDTH  = WB_AW,
    parameter int                                   WB_SEL_WIDTH   = WB_SW,
    parameter int                                   NUM_SLAVES     = WB_NUM_SLAVES,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]  SLAVE_BASE     = WB_DEF_BASE,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]  SLAVE_MASK     = WB_DEF_MASK,
    parameter int                                   TIMEOUT_CYCLES = 256
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic [WB_ADDR_WIDTH-1:0]               wbm_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]               wbm_dat_i,
    input  logic [WB_SEL_WIDTH-1:0]                wbm_sel_i,
    input  logic                                   wbm_we_i,
    input  logic                                   wbm_stb_i,
    input  logic                                   wbm_cyc_i,
    output logic                                   wbm_ack_o,
    output logic                                   wbm_err_o,
    output logic [WB_DATA_WIDTH-1:0]               wbm_dat_o,
    output logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]    wbs_adr_o,
    output logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]    wbs_dat_o,
    output logic [NUM_SLAVES*WB_SEL_WIDTH-1:0]     wbs_sel_o,
    output logic [NUM_SLAVES-1:0]                  wbs_we_o,
    output logic [NUM_SLAVES-1:0]                  wbs_stb_o,
    output logic [NUM_SLAVES-1:0]                  wbs_cyc_o,
    input  logic [NUM_SLAVES-1:0]                  wbs_ack_i,
    input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]    wbs_dat_i,
    output logic [WB_ADDR_WIDTH-1:0]               err_addr_o
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    wb_state_e                  r_state;
    logic [IW-1:0]              r_idx;
    logic [WB_ADDR_WIDTH-1:0]   r_adr;
    logic [WB_DATA_WIDTH-1:0]   r_dat;
    logic [WB_SEL_WIDTH-1:0]    r_sel;
    logic                       r_we;
    logic [NUM_SLAVES-1:0]      r_stb;
    logic                       r_ack;
    logic                       r_err;
    logic [WB_DATA_WIDTH-1:0]   r_rdat;
    logic [WB_ADDR_WIDTH-1:0]   r_err_addr;
    logic [CW-1:0]              r_cnt;

    logic                       w_hit;
    logic [IW-1:0]              w_idx;
    logic [NUM_SLAVES-1:0]      w_onehot;
    logic                       w_ack_sel;
    logic [WB_DATA_WIDTH-1:0]   w_rdat_sel;
    logic                       w_timeout;

    wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .AW         (WB_ADDR_WIDTH),
        .IW         (IW),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .i_adr (wbm_adr_i),
        .o_hit (w_hit),
        .o_idx (w_idx)
    );

    always_comb begin
        w_onehot   = '0;
        w_ack_sel  = 1'b0;
        w_rdat_sel = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_onehot[k] = (w_idx == IW'(k));
            if (r_idx == IW'(k)) begin
                w_ack_sel  = wbs_ack_i[k];
                w_rdat_sel = wbs_dat_i[k*WB_DATA_WIDTH +: WB_DATA_WIDTH];
            end
        end
    end

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_sel      <= '0;
            r_we       <= 1'b0;
            r_stb      <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdat     <= '0;
            r_err_addr <= '0;
            r_cnt      <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        if (w_hit) begin
                            r_idx   <= w_idx;
                            r_adr   <= wbm_adr_i;
                            r_dat   <= wbm_dat_i;
                            r_sel   <= wbm_sel_i;
                            r_we    <= wbm_we_i;
                            r_stb   <= w_onehot;
                            r_cnt   <= '0;
                            r_state <= ST_ACTIVE;
                        end else begin
                            r_err_addr <= wbm_adr_i;
                            r_err      <= 1'b1;
                            r_state    <= ST_ERR;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Master abort beats ack, ack beats time-out
                    if (!wbm_cyc_i) begin
                        r_stb   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_ack_sel) begin
                        r_rdat  <= w_rdat_sel;
                        r_stb   <= '0;
                        r_ack   <= 1'b1;
                        r_state <= ST_RESP;
                    end else if (w_timeout) begin
                        r_stb      <= '0;
                        r_err_addr <= r_adr;
                        r_err      <= 1'b1;
                        r_state    <= ST_ERR;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wbm_ack_o  = r_ack;
    assign wbm_err_o  = r_err;
    assign wbm_dat_o  = r_rdat;
    assign err_addr_o = r_err_addr;
    assign wbs_adr_o  = {NUM_SLAVES{r_adr}};
    assign wbs_dat_o  = {NUM_SLAVES{r_dat}};
    assign wbs_sel_o  = {NUM_SLAVES{r_sel}};
    assign wbs_we_o   = r_stb & {NUM_SLAVES{r_we}};
    assign wbs_stb_o  = r_stb;
    assign wbs_cyc_o  = r_stb;

endmodule

// File: tb/tb_wb_decoder_n.sv
// tb/tb_wb_decoder_n.sv - table-driven scoreboard bench for wb_decoder_n
module tb_wb_decoder_n;

    localparam int TO = 8;

    logic           clk_i = 1'b0;
    logic           rst_n_i = 1'b0;
    logic [31:0]    wbm_adr_i = '0;
    logic [31:0]    wbm_dat_i = '0;
    logic [3:0]     wbm_sel_i = '0;
    logic           wbm_we_i = 1'b0;
    logic           wbm_stb_i = 1'b0;
    logic           wbm_cyc_i = 1'b0;
    logic           wbm_ack_o;
    logic           wbm_err_o;
    logic [31:0]    wbm_dat_o;
    logic [127:0]   wbs_adr_o;
    logic [127:0]   wbs_dat_o;
    logic [15:0]    wbs_sel_o;
    logic [3:0]     wbs_we_o;
    logic [3:0]     wbs_stb_o;
    logic [3:0]     wbs_cyc_o;
    logic [3:0]     wbs_ack_i = '0;
    logic [127:0]   wbs_dat_i = '0;
    logic [31:0]    err_addr_o;

    wb_decoder_n #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_stb_i(wbm_stb_i), .wbm_cyc_i(wbm_cyc_i),
        .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_dat_o(wbm_dat_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o),
        .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i), .err_addr_o(err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          lat;
        logic        noise;
        logic [31:0] rdat;
        logic [3:0]  exp_stb;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        logic [31:0] eaddr;
        int          cyc;
    } sb_t;

    vec_t vecs[10];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stb"},  wbs_stb_o, 0);
        check({tag, "_cyc"},  wbs_cyc_o, 0);
        check({tag, "_we"},   wbs_we_o, 0);
        check({tag, "_sadr"}, wbs_adr_o, 0);
        check({tag, "_sdat"}, wbs_dat_o, 0);
        check({tag, "_ssel"}, wbs_sel_o, 0);
        check({tag, "_ack"},  wbm_ack_o, 0);
        check({tag, "_err"},  wbm_err_o, 0);
        check({tag, "_mdat"}, wbm_dat_o, 0);
        check({tag, "_eadr"}, err_addr_o, 0);
    endtask

    // Drives one master transfer and plays the selected slave with the vector's ack latency
    task automatic run_xfer(input vec_t v, input int id);
        sb_t e;
        sb_t got_e;
        int  tgt;
        int  stb_cnt;
        bit  done;
        bit  stb_seen;
        tgt = -1;
        for (int k = 0; k < 4; k++) begin
            wbs_dat_i[k*32 +: 32] = v.exp_stb[k] ? v.rdat : (32'hBAD0_0000 | 32'(k));
            if (v.exp_stb[k]) tgt = k;
        end
        e.err   = v.exp_err;
        e.dat   = v.rdat;
        e.eaddr = v.adr;
        e.cyc   = (tgt < 0) ? 0 : (v.exp_err ? TO : v.lat + 1);
        sb_q.push_back(e);
        wbm_adr_i = v.adr;
        wbm_dat_i = v.dat;
        wbm_sel_i = v.sel;
        wbm_we_i  = v.we;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        stb_cnt = 0;
        done = 1'b0;
        stb_seen = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            cycle();
            wbs_ack_i = '0;
            if (wbs_stb_o != '0) begin
                if (!stb_seen) begin
                    stb_seen = 1'b1;
                    check($sformatf("v%0d_stb", id), wbs_stb_o, v.exp_stb);
                    check($sformatf("v%0d_cyc", id), wbs_cyc_o, wbs_stb_o);
                    check($sformatf("v%0d_we", id), wbs_we_o, v.we ? v.exp_stb : 4'b0);
                    if (tgt >= 0) begin
                        check($sformatf("v%0d_sadr", id), wbs_adr_o[tgt*32 +: 32], v.adr);
                        check($sformatf("v%0d_sdat", id), wbs_dat_o[tgt*32 +: 32], v.dat);
                        check($sformatf("v%0d_ssel", id), wbs_sel_o[tgt*4 +: 4], v.sel);
                    end
                end
                if (stb_cnt == v.lat) wbs_ack_i = v.exp_stb;
                else if (v.noise) wbs_ack_i = ~v.exp_stb;
                stb_cnt++;
            end
            if (wbm_ack_o || wbm_err_o) begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d_sb_empty", id), 1, 0);
                end else begin
                    got_e = sb_q.pop_front();
                    check($sformatf("v%0d_ackerr", id), {wbm_ack_o, wbm_err_o},
                          got_e.err ? 2'b01 : 2'b10);
                    check($sformatf("v%0d_latency", id), c, got_e.cyc);
                    if (got_e.err) check($sformatf("v%0d_eaddr", id), err_addr_o, got_e.eaddr);
                    else           check($sformatf("v%0d_rdat", id), wbm_dat_o, got_e.dat);
                end
            end
        end
        if (!done) begin
            check($sformatf("v%0d_no_response", id), 0, 1);
            sb_q.delete();
        end
        if (tgt < 0) check($sformatf("v%0d_miss_no_stb", id), stb_seen, 0);
        else if (v.exp_err) check($sformatf("v%0d_to_stb_cycles", id), stb_cnt, TO);
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbs_ack_i = '0;
        cycle();
        check($sformatf("v%0d_pulse_end", id), {wbm_ack_o, wbm_err_o}, 2'b00);
        check($sformatf("v%0d_stb_end", id), wbs_stb_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        bit ok;
        //          adr            dat            sel      we    lat   noise rdat           stb      err
        vecs[0] = '{32'h0000_0010, 32'h0,         4'hF,    1'b0, 1,    1'b0, 32'hDEAD_BEEF, 4'b0001, 1'b0};
        vecs[1] = '{32'h8000_1004, 32'h41,        4'b0001, 1'b1, 0,    1'b0, 32'h0,         4'b0100, 1'b0};
        vecs[2] = '{32'h4000_0000, 32'h0,         4'hF,    1'b0, 0,    1'b0, 32'h0,         4'b0000, 1'b1};
        vecs[3] = '{32'h8000_0ABC, 32'h0,         4'hF,    1'b0, 2,    1'b1, 32'h1234_5678, 4'b0010, 1'b0};
        vecs[4] = '{32'h8000_2FFC, 32'h0,         4'hF,    1'b0, 0,    1'b0, 32'hCAFE_F00D, 4'b1000, 1'b0};
        vecs[5] = '{32'h0000_7FFC, 32'h0,         4'hF,    1'b0, 0,    1'b0, 32'hA5A5_5A5A, 4'b0001, 1'b0};
        vecs[6] = '{32'h0000_8000, 32'h0,         4'hF,    1'b0, 0,    1'b0, 32'h0,         4'b0000, 1'b1};
        vecs[7] = '{32'h8000_3000, 32'h0,         4'hF,    1'b0, 0,    1'b0, 32'h0,         4'b0000, 1'b1};
        vecs[8] = '{32'h0000_0100, 32'h1122_3344, 4'b1100, 1'b1, 3,    1'b1, 32'h0,         4'b0001, 1'b0};
        vecs[9] = '{32'h8000_0000, 32'h0,         4'hF,    1'b0, 1000, 1'b0, 32'h0,         4'b0010, 1'b1};

        rst_n_i = 1'b0;
        repeat (3) cycle();
        check_all_zero("reset");
        rst_n_i = 1'b1;
        cycle();

        for (int i = 0; i < 10; i++) run_xfer(vecs[i], i);

        // Abort two cycles into ACTIVE
        wbs_dat_i = '0;
        wbm_adr_i = 32'h0000_0010;
        wbm_we_i  = 1'b0;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 8 && !ok; c++) begin
            cycle();
            if (wbs_stb_o != '0) ok = 1'b1;
        end
        check("abort_stb_up", ok, 1);
        cycle();
        check("abort_stb_held", wbs_stb_o, 4'b0001);
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        cycle();
        check("abort_stb_drop", wbs_stb_o, 0);
        saw = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (wbm_ack_o || wbm_err_o) saw = 1'b1;
        end
        check("abort_no_resp", saw, 0);
        run_xfer(vecs[0], 100);

        // Asynchronous reset while a slave is strobed
        wbm_adr_i = 32'h8000_1004;
        wbm_dat_i = 32'h41;
        wbm_we_i  = 1'b1;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 8 && !ok; c++) begin
            cycle();
            if (wbs_stb_o != '0) ok = 1'b1;
        end
        check("rst_stb_up", ok, 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_all_zero("async_rst");
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cycle();
        run_xfer(vecs[1], 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
